fault_inject_guard: RTL
=======================

// Module: fault_inject_guard
// PURPOSE
//  Sequential fault injector on a WIDTH-bit signal path; write-side counterpart of guarded assertion monitors.
//  Sits inline between a driver (I) and its consumers (O).
//  A config handshake arms the block. After a programmed delay it corrupts O for a programmed duration using a mask and mode.
//  Outside injection, O == I combinationally (zero latency).
// PARAMETERS
//  WIDTH   8   data path width of I/O and mask
//  CNT_W   16  width of delay/duration counters and inject_count
// PORTS
//  CLK          in   1      clock; all state updates on rising edge
//  RESETN       in   1      synchronous reset, active-low
//  I            in   WIDTH  data from driver
//  O            out  WIDTH  data to consumers (possibly corrupted)
//  cfg_valid    in   1      config request
//  cfg_ready    out  1      block can accept config
//  cfg_delay    in   CNT_W  cycles to wait in ARM before injecting
//  cfg_duration in   CNT_W  cycles to hold INJECT; 0 = no injection
//  cfg_mask     in   WIDTH  bits affected
//  cfg_mode     in   2      0 flip, 1 stuck-0, 2 stuck-1, 3 random (see CONFIGURATION)
//  abort        in   1      cancel armed/active injection
//  active       out  1      high while state==INJECT
//  done         out  1      high while state==DONE
//  inject_count out  CNT_W  completed injection windows, saturating
// BEHAVIOUR
//  Reset (RESETN==0 at edge):
//   - state=IDLE; counters, stored mask/mode, and inject_count = 0.
//   - Outputs: O=I, cfg_ready=1, active=0, done=0.
//   - Reset mid-INJECT releases O on the next cycle; no partial count.
//  FSM states: IDLE, ARM, INJECT, DONE.
//  cfg_ready = (state==IDLE || state==DONE) && !abort. Accept = cfg_valid && cfg_ready.
//  Accept at edge t latches delay, duration, mask, mode. Next state:
//   - duration==0 -> DONE; inject_count unchanged.
//   - delay==0    -> INJECT.
//   - otherwise   -> ARM, with dcnt=delay.
//  ARM: dcnt decrements each cycle. At dcnt==1, next state is INJECT with icnt=duration.
//   - Resulting injection starts exactly delay+1 cycles after the accept edge.
//  INJECT: O corrupted every cycle; icnt decrements.
//   - At icnt==1: next state DONE, inject_count += 1 (saturates at all-ones).
//   - Injection lasts exactly duration cycles.
//  Corruption per bit b where mask[b]=1:
//   - mode 0: O[b] = ~I[b]
//   - mode 1: O[b] = 0
//   - mode 2: O[b] = 1
//   - mode 3: O[b] = I[b] ^ lfsr[b]
//  Bits with mask=0 pass through unchanged. Mask 0 is legal: window still counted, O unchanged.
//  DONE persists until the next accept or abort. Accept in DONE behaves as accept in IDLE.
//  abort=1 in ARM/INJECT/DONE: next state IDLE.
//   - Current-cycle O is unaffected.
//   - An aborted INJECT window is not counted.
//  abort and cfg_valid together: abort wins; config dropped, since cfg_ready=0.
//  cfg fields are ignored while cfg_ready=0; the stored config is immutable while armed.
// CONFIGURATION
//  FAULT_INJECT_LFSR_EN defined:
//   - Instantiates a WIDTH-bit Galois LFSR, seed all-ones at reset, advancing only in INJECT.
//   - Mode 3 uses the LFSR output.
//  FAULT_INJECT_LFSR_EN undefined:
//   - No LFSR logic.
//   - Mode 3 leaves O=I through the window; the window still runs and is counted.
// STRUCTURE
//  Package fault_inject_pkg:
//   - fi_state_e {IDLE, ARM, INJECT, DONE}
//   - fi_mode_e {FI_FLIP, FI_STUCK0, FI_STUCK1, FI_RAND}
//   - localparam LFSR taps table by WIDTH.
//  Sub-module fault_lfsr (WIDTH; CLK, RESETN, en, q), instantiated only under FAULT_INJECT_LFSR_EN.
// TESTING
//  1. Reset: RESETN=0 with I=8'hA5 -> O=8'hA5, cfg_ready=1, active=0, done=0, inject_count=0.
//  2. Flip, delay=3, dur=2, mask=8'h0F, I=8'h00, accept at t:
//     - O=8'h0F on cycles t+4 and t+5; O=8'h00 otherwise.
//     - done=1 from t+6; inject_count=1.
//  3. Stuck-1, delay=0, dur=1, mask=8'hFF -> O=8'hFF on t+1 only. Then stuck-0 re-accepted from DONE: same timing with O=8'h00.
//  4. Abort during INJECT (dur=10) on 3rd inject cycle -> corruption ends next cycle, state IDLE, inject_count unchanged.
//  5. duration=0 accept -> DONE at t+1, O never corrupted, count unchanged. abort+cfg_valid together -> no accept.
//  6. Mode 3, mask=8'hFF: with FAULT_INJECT_LFSR_EN, O differs from I in >=1 cycle of a 16-cycle window; without it, O==I throughout and count=1.

Source files
------------

// File: rtl/fault_inject_pkg.sv
// -----------------------------------------------------------------------------
// fault_inject_pkg
// Shared types and constants for the fault_inject_guard block.
//   fi_state_e  : injector FSM states
//   fi_mode_e   : corruption modes applied to masked bits
//   LFSR_TAPS   : maximal-length Galois feedback masks (right-shift form),
//                 indexed by LFSR width 2..32
// -----------------------------------------------------------------------------
package fault_inject_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    INJECT = 2'd2,
    DONE   = 2'd3
  } fi_state_e;

  typedef enum logic [1:0] {
    FI_FLIP   = 2'd0,
    FI_STUCK0 = 2'd1,
    FI_STUCK1 = 2'd2,
    FI_RAND   = 2'd3
  } fi_mode_e;

  localparam int LFSR_MIN_W = 2;
  localparam int LFSR_MAX_W = 32;

  localparam logic [LFSR_MAX_W-1:0] LFSR_TAPS [LFSR_MIN_W:LFSR_MAX_W] = '{
    32'h0000_0003, 32'h0000_0006, 32'h0000_000C, 32'h0000_0014,
    32'h0000_0030, 32'h0000_0060, 32'h0000_00B8, 32'h0000_0110,
    32'h0000_0240, 32'h0000_0500, 32'h0000_0829, 32'h0000_100D,
    32'h0000_2015, 32'h0000_6000, 32'h0000_D008, 32'h0001_2000,
    32'h0002_0400, 32'h0004_0023, 32'h0009_0000, 32'h0014_0000,
    32'h0030_0000, 32'h0042_0000, 32'h00E1_0000, 32'h0120_0000,
    32'h0200_0023, 32'h0400_0013, 32'h0900_0000, 32'h1400_0000,
    32'h2000_0029, 32'h4800_0000, 32'h8020_0003
  };

endpackage

// File: rtl/fault_lfsr.sv
// -----------------------------------------------------------------------------
// fault_lfsr
// WIDTH-bit Galois LFSR used as the pseudo-random source for the random
// corruption mode. Seeds to all-ones on reset and steps only while en=1.
// Ports:
//   CLK    in   clock, rising edge
//   RESETN in   synchronous reset, active-low
//   en     in   advance the sequence by one step this cycle
//   q      out  current LFSR state (WIDTH bits)
// WIDTH must lie in 2..32.
// -----------------------------------------------------------------------------
module fault_lfsr
  import fault_inject_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  localparam logic [LFSR_MAX_W-1:0] TAPS_FULL = LFSR_TAPS[WIDTH];
  localparam logic [WIDTH-1:0]      TAPS      = TAPS_FULL[WIDTH-1:0];

  // Galois form: shift right, fold the feedback mask in when the bit leaving
  // the register is 1.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      q <= '1;
    end else if (en) begin
      q <= (q >> 1) ^ (q[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/fault_inject_guard.sv
// -----------------------------------------------------------------------------
// fault_inject_guard
// Inline fault injector on a WIDTH-bit path. A config handshake arms the
// block; after cfg_delay cycles it corrupts O for cfg_duration cycles using
// cfg_mask/cfg_mode. Outside the injection window O follows I with zero
// latency.
//
// Optional feature macro: FAULT_INJECT_LFSR_EN
//   defined   : a fault_lfsr supplies the pattern for random mode
//   undefined : no LFSR; random mode leaves O=I while the window still runs
//
// Ports:
//   CLK, RESETN          clock / synchronous active-low reset
//   I, O                 data in from driver / data out to consumers
//   cfg_valid, cfg_ready config handshake
//   cfg_delay            cycles spent armed before injecting
//   cfg_duration         injection length in cycles (0 = no injection)
//   cfg_mask, cfg_mode   affected bits and corruption mode
//   abort                cancel armed / active / done state
//   active, done         state is INJECT / DONE
//   inject_count         completed injection windows, saturating
// -----------------------------------------------------------------------------
module fault_inject_guard
  import fault_inject_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_duration,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic [1:0]       cfg_mode,
  input  logic             abort,
  output logic             active,
  output logic             done,
  output logic [CNT_W-1:0] inject_count
);

  fi_state_e        state;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] icnt;
  logic [WIDTH-1:0] mask_q;
  fi_mode_e         mode_q;
  logic             accept;
  logic [WIDTH-1:0] corrupt;

  assign cfg_ready = ((state == IDLE) || (state == DONE)) && !abort;
  assign accept    = cfg_valid && cfg_ready;
  assign active    = (state == INJECT);
  assign done      = (state == DONE);

`ifdef FAULT_INJECT_LFSR_EN
  logic [WIDTH-1:0] lfsr_q;

  fault_lfsr #(
    .WIDTH (WIDTH)
  ) u_lfsr (
    .CLK    (CLK),
    .RESETN (RESETN),
    .en     (state == INJECT),
    .q      (lfsr_q)
  );
`endif

  // Control: accept/abort arbitration and the delay/duration countdowns.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state        <= IDLE;
      dcnt         <= '0;
      icnt         <= '0;
      mask_q       <= '0;
      mode_q       <= FI_FLIP;
      inject_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            mask_q <= cfg_mask;
            mode_q <= fi_mode_e'(cfg_mode);
            dcnt   <= cfg_delay;
            icnt   <= cfg_duration;
            if (cfg_duration == '0) begin
              state <= DONE;
            end else if (cfg_delay == '0) begin
              state <= INJECT;
            end else begin
              state <= ARM;
            end
          end else if (abort) begin
            state <= IDLE;
          end
        end
        ARM: begin
          // icnt still holds the accepted duration, so INJECT starts fully loaded.
          if (abort) begin
            state <= IDLE;
          end else begin
            dcnt <= dcnt - 1'b1;
            if (dcnt == CNT_W'(1)) begin
              state <= INJECT;
            end
          end
        end
        INJECT: begin
          // An aborted window never reaches the counter update.
          if (abort) begin
            state <= IDLE;
          end else begin
            icnt <= icnt - 1'b1;
            if (icnt == CNT_W'(1)) begin
              state <= DONE;
              if (inject_count != '1) begin
                inject_count <= inject_count + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output path: stays combinational so the pass-through case has no latency.
  always_comb begin
    corrupt = I;
    case (mode_q)
      FI_FLIP:   corrupt = ~I;
      FI_STUCK0: corrupt = '0;
      FI_STUCK1: corrupt = '1;
`ifdef FAULT_INJECT_LFSR_EN
      FI_RAND:   corrupt = I ^ lfsr_q;
`else
      FI_RAND:   corrupt = I;
`endif
      default:   corrupt = I;
    endcase
  end

  always_comb begin
    O = I;
    if (state == INJECT) begin
      O = (I & ~mask_q) | (corrupt & mask_q);
    end
  end

endmodule
